// File: rtl/pwm_duty_decoder_pkg.sv
// Shared widths, types and helpers for the PWM duty decoder.
package pwm_duty_decoder_pkg;

    localparam int unsigned DUTY_W  = 11;
    localparam int unsigned CNT_W   = DUTY_W + 2;
    localparam int unsigned PERIOD  = 2 ** DUTY_W;
    localparam int unsigned TIMEOUT = 2 * PERIOD;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    // Interval counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t x);
        return (x == '1) ? x : x + cnt_t'(1);
    endfunction

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Measurement bus between the PWM line, the duty decoder and its consumer.
interface pwm_duty_decoder_if;
    import pwm_duty_decoder_pkg::*;

    logic  pwm_in;
    duty_t duty;
    cnt_t  period;
    logic  valid;
    logic  period_err;
    logic  stuck_hi;
    logic  stuck_lo;

    modport master (
        output pwm_in,
        input  duty, period, valid, period_err, stuck_hi, stuck_lo
    );

    modport slave (
        input  pwm_in,
        output duty, period, valid, period_err, stuck_hi, stuck_lo
    );
endinterface

// File: rtl/pwm_duty_decoder_in_sync.sv
// Input conditioning: 2-flop synchroniser, optional 3-sample agreement filter
// (PWM_DEC_GLITCH_FILTER_EN), and edge detection against the previous level.
module pwm_duty_decoder_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic sync1;
    logic sync2;
    logic prev;

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic hist0;
    logic hist1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist0 <= 1'b0;
            hist1 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            hist0 <= sync2;
            hist1 <= hist0;
            prev  <= level_c;
        end
    end

    // Level follows the line only once three consecutive synced samples agree.
    always_comb begin
        level_c = prev;
        if ((sync2 == hist0) && (hist0 == hist1)) begin
            level_c = sync2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level_c = sync2;
`endif

    assign rise_c = level_c & ~prev;
    assign fall_c = ~level_c & prev;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures an incoming PWM waveform and publishes duty/period once per period.
// Optional glitch filter selected by PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    pwm_duty_decoder_if.slave   pwm
);

    state_t state_q, state_d;
    cnt_t   hi_q, hi_d;
    cnt_t   per_q, per_d;
    cnt_t   gap_q, gap_d;
    duty_t  duty_q, duty_d;
    cnt_t   period_q, period_d;
    logic   valid_q, valid_d;
    logic   err_q, err_d;
    logic   shi_q, shi_d;
    logic   slo_q, slo_d;

    logic   level_c;
    logic   rise_c;
    logic   fall_c;
    logic   timeout_c;

    pwm_duty_decoder_in_sync u_in_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_in  (pwm.pwm_in),
        .level_c (level_c),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            per_q    <= '0;
            gap_q    <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            shi_q    <= 1'b0;
            slo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            per_q    <= per_d;
            gap_q    <= gap_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            shi_q    <= shi_d;
            slo_q    <= slo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        per_d     = per_q;
        gap_d     = gap_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        shi_d     = shi_q;
        slo_d     = slo_q;
        timeout_c = 1'b0;

        // Any edge clears the gap timer and suppresses a coincident timeout.
        if (rise_c || fall_c) begin
            gap_d = '0;
        end else begin
            gap_d     = sat_inc(gap_q);
            timeout_c = (gap_q == cnt_t'(TIMEOUT));
        end

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    hi_d    = cnt_t'(1);
                    per_d   = cnt_t'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                per_d = sat_inc(per_q);
                if (fall_c) begin
                    state_d = LOW;
                end else begin
                    hi_d = sat_inc(hi_q);
                end
            end
            LOW: begin
                if (rise_c) begin
                    duty_d   = (hi_q > cnt_t'(PERIOD)) ? '1 : DUTY_W'(hi_q - cnt_t'(1));
                    period_d = per_q;
                    err_d    = (per_q != cnt_t'(PERIOD));
                    shi_d    = 1'b0;
                    slo_d    = 1'b0;
                    valid_d  = 1'b1;
                    hi_d     = cnt_t'(1);
                    per_d    = cnt_t'(1);
                    state_d  = HIGH;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stuck line: report the held level and restart from IDLE.
        if (timeout_c) begin
            duty_d   = level_c ? '1 : '0;
            period_d = '0;
            err_d    = 1'b0;
            shi_d    = level_c;
            slo_d    = ~level_c;
            valid_d  = 1'b1;
            state_d  = IDLE;
        end
    end

    assign pwm.duty       = duty_q;
    assign pwm.period     = period_q;
    assign pwm.valid      = valid_q;
    assign pwm.period_err = err_q;
    assign pwm.stuck_hi   = shi_q;
    assign pwm.stuck_lo   = slo_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: waveform stimulus against an
// interval-based reference model (honours PWM_DEC_GLITCH_FILTER_EN).
module tb_pwm_duty_decoder;
    import pwm_duty_decoder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_duty_decoder_if dif ();

    pwm_duty_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm   (dif.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: line history, last rise/fall times, expected outputs.
    int unsigned cyc      = 0;
    int unsigned last_clr = 0;
    int unsigned t_rise   = 0;
    int unsigned t_fall   = 0;
    logic [3:0]  xh       = '0;
    logic        lvl_prev = 1'b0;
    bit          measuring = 1'b0;

    int unsigned e_duty   = 0;
    int unsigned e_period = 0;
    bit          e_valid  = 1'b0;
    bit          e_err    = 1'b0;
    bit          e_shi    = 1'b0;
    bit          e_slo    = 1'b0;

    task automatic model_step(input logic x, input logic rn);
        logic lvl;
        bit   rise;
        bit   fall;
        int unsigned hi_len;
        int unsigned per_len;
        cyc++;
        e_valid = 1'b0;
        if (!rn) begin
            xh        = '0;
            lvl_prev  = 1'b0;
            measuring = 1'b0;
            last_clr  = cyc;
            e_duty    = 0;
            e_period  = 0;
            e_err     = 1'b0;
            e_shi     = 1'b0;
            e_slo     = 1'b0;
            return;
        end
        // xh[i] holds the line value sampled i+1 edges ago.
`ifdef PWM_DEC_GLITCH_FILTER_EN
        lvl = ((xh[1] == xh[2]) && (xh[2] == xh[3])) ? xh[1] : lvl_prev;
`else
        lvl = xh[1];
`endif
        rise     = lvl && !lvl_prev;
        fall     = !lvl && lvl_prev;
        lvl_prev = lvl;
        xh       = {xh[2:0], x};

        if (rise || fall) last_clr = cyc;
        if (rise) begin
            if (measuring) begin
                hi_len   = t_fall - t_rise;
                per_len  = cyc - t_rise;
                e_duty   = (hi_len > PERIOD) ? PERIOD - 1 : hi_len - 1;
                e_period = (per_len > 8191) ? 8191 : per_len;
                e_err    = (e_period != PERIOD);
                e_shi    = 1'b0;
                e_slo    = 1'b0;
                e_valid  = 1'b1;
            end
            measuring = 1'b1;
            t_rise    = cyc;
        end else if (fall) begin
            t_fall = cyc;
        end else if (cyc - last_clr - 1 == TIMEOUT) begin
            e_duty    = lvl ? PERIOD - 1 : 0;
            e_period  = 0;
            e_err     = 1'b0;
            e_shi     = lvl;
            e_slo     = !lvl;
            e_valid   = 1'b1;
            measuring = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_step(dif.pwm_in, rst_n);
        #1;
        chk("valid",      32'(dif.valid),      32'(e_valid));
        chk("duty",       32'(dif.duty),       e_duty);
        chk("period",     32'(dif.period),     e_period);
        chk("period_err", 32'(dif.period_err), 32'(e_err));
        chk("stuck_hi",   32'(dif.stuck_hi),   32'(e_shi));
        chk("stuck_lo",   32'(dif.stuck_lo),   32'(e_slo));
    end

    task automatic drive(input logic v, input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            dif.pwm_in = v;
        end
    endtask

    task automatic wave(input int unsigned hi, input int unsigned per, input int unsigned reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
    endtask

    initial begin
        dif.pwm_in = 1'b0;
        drive(1'b0, 3);
        rst_n = 1'b1;

        // Line held low from reset, then 50% PWM at nominal period.
        drive(1'b0, 4200);
        wave(1024, 2048, 3);

        // Minimum-duty generator output (single-cycle pulse).
        wave(1, 2048, 3);

        // Maximum duty: constant high until the stuck-high report.
        drive(1'b1, 4300);
        drive(1'b0, 10);

        // Off-nominal period.
        wave(250, 1000, 3);

        // Reset in the middle of a high phase.
        drive(1'b1, 100);
        rst_n = 1'b0;
        drive(1'b1, 2);
        rst_n = 1'b1;
        drive(1'b1, 200);
        wave(300, 700, 3);

        // Single-cycle low glitch inside a high phase.
        wave(1024, 2048, 1);
        drive(1'b1, 300);
        drive(1'b0, 1);
        drive(1'b1, 723);
        drive(1'b0, 1024);
        wave(1024, 2048, 2);

        // Randomised waveforms, including near-minimum pulse widths.
        for (int i = 0; i < 6; i++) begin
            int unsigned hi;
            int unsigned lo;
            hi = $urandom_range(900, 1);
            lo = $urandom_range(900, 1);
            if (i == 0) hi = 2;
            wave(hi, hi + lo, 3);
        end
        drive(1'b0, 20);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
